// File: rtl/crack_pkg.sv
// crack_pkg: shared encodings for the password-recovery sequencer.
// Holds the progress-state encoding, the RGB LED codes, the fixed BRAM
// addresses of the hash and salt key, and the candidate-loop substates.
package crack_pkg;

  typedef enum logic [2:0] {
    ST_WAIT    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_DICT    = 3'd2,
    ST_BRUTE   = 3'd3,
    ST_SUCCESS = 3'd4,
    ST_FAIL    = 3'd5
  } crack_state_t;

  // RD/CAP fetch a word from BRAM, REQ pulses the encrypter, WT waits for it.
  typedef enum logic [1:0] {
    SUB_RD  = 2'd0,
    SUB_CAP = 2'd1,
    SUB_REQ = 2'd2,
    SUB_WT  = 2'd3
  } crack_sub_t;

  localparam logic [2:0] LED_WAIT    = 3'b011;
  localparam logic [2:0] LED_BUSY    = 3'b100;
  localparam logic [2:0] LED_SUCCESS = 3'b010;
  localparam logic [2:0] LED_FAIL    = 3'b001;

  localparam logic [7:0] HASH_ADDR = 8'd0;
  localparam logic [7:0] KEY_ADDR  = 8'd1;

  function automatic logic [2:0] led_code(input crack_state_t s);
    logic [2:0] code;
    case (s)
      ST_WAIT:    code = LED_WAIT;
      ST_SUCCESS: code = LED_SUCCESS;
      ST_FAIL:    code = LED_FAIL;
      default:    code = LED_BUSY;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/crack_watchdog.sv
// crack_watchdog: counts consecutive enabled cycles and raises timeout on the
// LIMIT-th one. clr has priority and returns the count to zero.
module crack_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [31:0] count;

  // Cycle counter; cleared whenever the watched wait is not in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

  assign timeout = en && (count == 32'(LIMIT - 1));

endmodule

// File: rtl/crack_sequencer.sv
// crack_sequencer: runs one password-recovery job. Loads hash and salt key
// from BRAM, then tries dictionary words and brute-force counter values
// through the shared encrypter until one encrypts to the stored hash.
// Optional feature macro: CRACK_TIMEOUT_EN adds an encrypter watchdog that
// fails the job after TIMEOUT_CYCLES wait cycles without enc_done.
//
// Handshake: enc_start is a one-cycle request; the encrypter answers with a
// one-cycle enc_done, enc_result valid only in that cycle. enc_done is
// consumed only in the WT substate and is ignored everywhere else.
module crack_sequencer
  import crack_pkg::*;
#(
  parameter int DICT_START     = 2,
  parameter int DICT_SIZE      = 3,
  parameter int BRUTE_ATTEMPTS = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         mem_en,
  output logic [7:0]   mem_addr,
  input  logic [127:0] mem_dout,
  output logic [127:0] enc_data,
  output logic [127:0] enc_key,
  output logic         enc_decrypt,
  output logic         enc_start,
  input  logic         enc_done,
  input  logic [127:0] enc_result,
  output logic [2:0]   state,
  output logic [2:0]   led,
  output logic         found,
  output logic [127:0] found_key,
  output logic [31:0]  attempts
);

  localparam logic [7:0] DICT_BASE = 8'(DICT_START);

  crack_state_t st_q, st_n;
  crack_sub_t   sub_q, sub_n;
  logic         load_key_q, load_key_n;
  logic [31:0]  idx_q, idx_n;
  logic [127:0] hash_q, hash_n;
  logic         start_q;
  logic         go_brute;
  logic         wd_timeout;

  logic         mem_en_n, enc_start_n, found_n;
  logic [7:0]   mem_addr_n;
  logic [127:0] data_n, key_n, fk_n;
  logic [31:0]  att_n;
  logic [2:0]   led_n;

  assign state       = st_q;
  assign enc_decrypt = 1'b0;

`ifdef CRACK_TIMEOUT_EN
  logic wd_en;
  assign wd_en = ((st_q == ST_DICT) || (st_q == ST_BRUTE)) && (sub_q == SUB_WT);

  crack_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (!wd_en),
    .en     (wd_en),
    .timeout(wd_timeout)
  );
`else
  // No watchdog: WT waits for enc_done forever, whatever TIMEOUT_CYCLES says.
  assign wd_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // State, datapath and output registers; reset aborts any job at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= ST_WAIT;
      sub_q      <= SUB_RD;
      load_key_q <= 1'b0;
      idx_q      <= '0;
      hash_q     <= '0;
      start_q    <= 1'b0;
      mem_en     <= 1'b0;
      mem_addr   <= '0;
      enc_data   <= '0;
      enc_key    <= '0;
      enc_start  <= 1'b0;
      led        <= 3'b000;
      found      <= 1'b0;
      found_key  <= '0;
      attempts   <= '0;
    end else begin
      st_q       <= st_n;
      sub_q      <= sub_n;
      load_key_q <= load_key_n;
      idx_q      <= idx_n;
      hash_q     <= hash_n;
      start_q    <= start;
      mem_en     <= mem_en_n;
      mem_addr   <= mem_addr_n;
      enc_data   <= data_n;
      enc_key    <= key_n;
      enc_start  <= enc_start_n;
      led        <= led_n;
      found      <= found_n;
      found_key  <= fk_n;
      attempts   <= att_n;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    st_n        = st_q;
    sub_n       = sub_q;
    load_key_n  = load_key_q;
    idx_n       = idx_q;
    hash_n      = hash_q;
    data_n      = enc_data;
    key_n       = enc_key;
    fk_n        = found_key;
    att_n       = attempts;
    go_brute    = 1'b0;
    mem_en_n    = 1'b0;
    mem_addr_n  = mem_addr;
    enc_start_n = 1'b0;

    case (st_q)
      ST_WAIT: begin
        if (start && !start_q) begin
          st_n       = ST_LOAD;
          sub_n      = SUB_RD;
          load_key_n = 1'b0;
          idx_n      = '0;
          att_n      = '0;
          fk_n       = '0;
        end
      end

      ST_LOAD: begin
        if (sub_q == SUB_CAP) begin
          if (!load_key_q) begin
            hash_n     = mem_dout;
            load_key_n = 1'b1;
            sub_n      = SUB_RD;
          end else begin
            key_n = mem_dout;
            if (DICT_SIZE == 0) begin
              go_brute = 1'b1;
            end else begin
              st_n  = ST_DICT;
              sub_n = SUB_RD;
              idx_n = '0;
            end
          end
        end else begin
          sub_n = SUB_CAP;
        end
      end

      ST_DICT, ST_BRUTE: begin
        case (sub_q)
          SUB_RD:  sub_n = SUB_CAP;
          SUB_CAP: begin
            data_n = mem_dout;
            sub_n  = SUB_REQ;
          end
          SUB_REQ: sub_n = SUB_WT;
          default: begin
            if (enc_done) begin
              att_n = attempts + 32'd1;
              if (enc_result == hash_q) begin
                fk_n = enc_data;
                st_n = ST_SUCCESS;
              end else begin
                idx_n = idx_q + 32'd1;
                if (st_q == ST_DICT) begin
                  if (idx_n == 32'(DICT_SIZE)) begin
                    go_brute = 1'b1;
                  end else begin
                    sub_n = SUB_RD;
                  end
                end else if (idx_n == 32'(BRUTE_ATTEMPTS)) begin
                  st_n = ST_FAIL;
                end else begin
                  sub_n  = SUB_REQ;
                  data_n = {96'b0, idx_n};
                end
              end
            end else if (wd_timeout) begin
              st_n = ST_FAIL;
            end
          end
        endcase
      end

      default: begin
        // SUCCESS and FAIL hold until reset.
      end
    endcase

    // Brute phase starts from candidate 0, straight into its request.
    if (go_brute) begin
      idx_n = '0;
      if (BRUTE_ATTEMPTS == 0) begin
        st_n = ST_FAIL;
      end else begin
        st_n   = ST_BRUTE;
        sub_n  = SUB_REQ;
        data_n = '0;
      end
    end

    // BRAM address is presented for exactly the RD cycle.
    if (sub_n == SUB_RD && st_n == ST_LOAD) begin
      mem_en_n   = 1'b1;
      mem_addr_n = load_key_n ? KEY_ADDR : HASH_ADDR;
    end else if (sub_n == SUB_RD && st_n == ST_DICT) begin
      mem_en_n   = 1'b1;
      mem_addr_n = DICT_BASE + idx_n[7:0];
    end

    enc_start_n = (sub_n == SUB_REQ) && ((st_n == ST_DICT) || (st_n == ST_BRUTE));
    led_n       = led_code(st_n);
    found_n     = (st_n == ST_SUCCESS);
  end

endmodule

// File: tb/tb_crack_sequencer.sv
// tb_crack_sequencer: directed bench for crack_sequencer. Two instances share
// one BRAM model and one encrypter model (result = data ^ key, latency 3);
// sel chooses which instance is driven and observed. Instance a uses the
// default parameters, instance z has an empty dictionary.
module tb_crack_sequencer;

  localparam logic [127:0] K  = {16{8'h0F}};
  localparam logic [127:0] D0 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] D1 = 128'hCAFE_F00D_DEAD_BEEF_1234_5678_9ABC_DEF0;
  localparam logic [127:0] D2 = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_m = 1'b0;
  logic         sel = 1'b0;
  logic         enc_mute = 1'b0;
  logic [127:0] mem [0:255];
  logic [127:0] mem_dout = '0;
  logic         enc_done = 1'b0;
  logic [127:0] enc_result = '0;
  logic [127:0] enc_res_q = '0;
  int           enc_cnt = 0;
  int           pulses = 0;

  logic start_a, start_z;
  logic mem_en_a, mem_en_z, enc_dec_a, enc_dec_z, enc_start_a, enc_start_z, found_a, found_z;
  logic [7:0] mem_addr_a, mem_addr_z;
  logic [127:0] enc_data_a, enc_data_z, enc_key_a, enc_key_z, fk_a, fk_z;
  logic [2:0] state_a, state_z, led_a, led_z;
  logic [31:0] att_a, att_z;

  logic         m_mem_en, m_enc_start, m_found, m_enc_dec;
  logic [7:0]   m_mem_addr;
  logic [127:0] m_enc_data, m_enc_key, m_fk;
  logic [2:0]   m_state, m_led;
  logic [31:0]  m_att;

  assign start_a     = start_m & ~sel;
  assign start_z     = start_m & sel;
  assign m_mem_en    = sel ? mem_en_z    : mem_en_a;
  assign m_mem_addr  = sel ? mem_addr_z  : mem_addr_a;
  assign m_enc_data  = sel ? enc_data_z  : enc_data_a;
  assign m_enc_key   = sel ? enc_key_z   : enc_key_a;
  assign m_enc_start = sel ? enc_start_z : enc_start_a;
  assign m_enc_dec   = sel ? enc_dec_z   : enc_dec_a;
  assign m_state     = sel ? state_z     : state_a;
  assign m_led       = sel ? led_z       : led_a;
  assign m_found     = sel ? found_z     : found_a;
  assign m_fk        = sel ? fk_z        : fk_a;
  assign m_att       = sel ? att_z       : att_a;

  crack_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .mem_en(mem_en_a), .mem_addr(mem_addr_a), .mem_dout(mem_dout),
    .enc_data(enc_data_a), .enc_key(enc_key_a), .enc_decrypt(enc_dec_a),
    .enc_start(enc_start_a), .enc_done(enc_done), .enc_result(enc_result),
    .state(state_a), .led(led_a), .found(found_a), .found_key(fk_a),
    .attempts(att_a)
  );

  crack_sequencer #(.DICT_SIZE(0)) dut_z (
    .clk(clk), .reset(reset), .start(start_z),
    .mem_en(mem_en_z), .mem_addr(mem_addr_z), .mem_dout(mem_dout),
    .enc_data(enc_data_z), .enc_key(enc_key_z), .enc_decrypt(enc_dec_z),
    .enc_start(enc_start_z), .enc_done(enc_done), .enc_result(enc_result),
    .state(state_z), .led(led_z), .found(found_z), .found_key(fk_z),
    .attempts(att_z)
  );

  // Clock.
  always #5 clk = ~clk;

  // BRAM model: data one cycle after an enabled address.
  always @(posedge clk) begin
    if (m_mem_en) mem_dout <= mem[m_mem_addr];
  end

  // Encrypter model: not reset, so a request in flight still answers later.
  always @(posedge clk) begin
    enc_done <= 1'b0;
    if (m_enc_start) pulses <= pulses + 1;
    if (m_enc_start && !enc_mute) begin
      enc_cnt   <= 3;
      enc_res_q <= m_enc_data ^ m_enc_key;
    end else if (enc_cnt != 0) begin
      enc_cnt <= enc_cnt - 1;
      if (enc_cnt == 1) begin
        enc_done   <= 1'b1;
        enc_result <= enc_res_q;
      end
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    start_m = 1'b0;
    reset   = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic load_mem(input logic [127:0] hash);
    mem[0] = hash;
    mem[1] = K;
    mem[2] = D0;
    mem[3] = D1;
    mem[4] = D2;
  endtask

  task automatic pulse_start();
    start_m = 1'b1;
    repeat (2) @(negedge clk);
    start_m = 1'b0;
  endtask

  task automatic wait_terminal(input string name);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (m_state == 3'd4 || m_state == 3'd5) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_terminal"}, 128'(ok), 128'd1);
  endtask

  task automatic wait_state(input string name, input logic [2:0] s);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (m_state == s) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_reach"}, 128'(ok), 128'd1);
  endtask

  typedef struct {
    string        name;
    logic         inst;
    logic [127:0] hash;
    logic [2:0]   exp_state;
    logic [31:0]  exp_att;
    logic         exp_found;
    logic [127:0] exp_key;
    logic [2:0]   exp_led;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int p0;
    logic ok;
    int n;

    for (int i = 0; i < 256; i++) mem[i] = '0;

    vecs[0] = '{"dict_hit",  1'b0, D1 ^ K,        3'd4, 32'd2,  1'b1, D1,      3'b010};
    vecs[1] = '{"brute_7",   1'b0, 128'd7 ^ K,    3'd4, 32'd11, 1'b1, 128'd7,  3'b010};
    vecs[2] = '{"no_match",  1'b0, 128'hDEAD ^ K, 3'd5, 32'd13, 1'b0, 128'd0,  3'b001};
    vecs[3] = '{"empty_dict",1'b1, K,             3'd4, 32'd1,  1'b1, 128'd0,  3'b010};

    // Reset values, sampled while reset is held.
    repeat (2) @(negedge clk);
    check("rst_state",     128'(state_a),     128'd0);
    check("rst_led",       128'(led_a),       128'd0);
    check("rst_mem_en",    128'(mem_en_a),    128'd0);
    check("rst_enc_start", 128'(enc_start_a), 128'd0);
    check("rst_found",     128'(found_a),     128'd0);
    check("rst_attempts",  128'(att_a),       128'd0);
    check("rst_found_key", fk_a,              128'd0);
    check("rst_state_z",   128'(state_z),     128'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("wait_led",      128'(led_a),       128'b011);
    check("wait_state",    128'(state_a),     128'd0);
    check("enc_decrypt",   128'(enc_dec_a),   128'd0);

    // Full jobs from the vector table.
    for (int v = 0; v < 4; v++) begin
      sel = vecs[v].inst;
      do_reset();
      load_mem(vecs[v].hash);
      pulse_start();
      wait_terminal(vecs[v].name);
      @(negedge clk);
      check({vecs[v].name, "_state"},     128'(m_state), 128'(vecs[v].exp_state));
      check({vecs[v].name, "_attempts"},  128'(m_att),   128'(vecs[v].exp_att));
      check({vecs[v].name, "_found"},     128'(m_found), 128'(vecs[v].exp_found));
      check({vecs[v].name, "_found_key"}, m_fk,          vecs[v].exp_key);
      check({vecs[v].name, "_led"},       128'(m_led),   128'(vecs[v].exp_led));
      check({vecs[v].name, "_key"},       m_enc_key,     K);
    end

    // Start edges inside DICT and inside SUCCESS are ignored.
    sel = 1'b0;
    do_reset();
    load_mem(D1 ^ K);
    pulse_start();
    wait_state("ign_dict", 3'd2);
    pulse_start();
    @(negedge clk);
    check("ign_dict_state", 128'(m_state), 128'd2);
    wait_terminal("ign_dict");
    check("ign_dict_attempts", 128'(m_att), 128'd2);
    p0 = pulses;
    pulse_start();
    repeat (20) @(negedge clk);
    check("ign_succ_state",    128'(m_state), 128'd4);
    check("ign_succ_attempts", 128'(m_att),   128'd2);
    check("ign_succ_pulses",   128'(pulses),  128'(p0));

    // Reset during WT of candidate 2, late enc_done afterwards.
    do_reset();
    load_mem(128'hDEAD ^ K);
    p0 = pulses;
    pulse_start();
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (pulses == p0 + 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("midrst_reach_req2", 128'(ok), 128'd1);
    reset = 1'b1;
    #1;
    check("midrst_state_now", 128'(m_state),     128'd0);
    check("midrst_start_now", 128'(m_enc_start), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst_state",    128'(m_state), 128'd0);
    check("midrst_pulses",   128'(pulses),  128'(p0 + 2));
    check("midrst_attempts", 128'(m_att),   128'd0);
    check("midrst_led",      128'(m_led),   128'b011);
    load_mem(D1 ^ K);
    pulse_start();
    wait_terminal("restart");
    check("restart_state",     128'(m_state), 128'd4);
    check("restart_attempts",  128'(m_att),   128'd2);
    check("restart_found_key", m_fk,          D1);

`ifdef CRACK_TIMEOUT_EN
    // Encrypter never answers: watchdog fails the job.
    enc_mute = 1'b1;
    do_reset();
    load_mem(D1 ^ K);
    pulse_start();
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (m_enc_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("to_reach_req", 128'(ok), 128'd1);
    n = 0;
    while (m_state != 3'd5 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles",   128'(n),       128'(TO + 1));
    check("to_attempts", 128'(m_att),   128'd0);
    check("to_led",      128'(m_led),   128'b001);
    enc_mute = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/crack_sequencer.md
# crack_sequencer

Registered controller that runs one password-recovery job end to end. It loads the target hash and salt key from the SD-simulation BRAM, then tests candidates against the hash through the shared encrypter: first dictionary words stored in BRAM, then brute-force counter values. It reports the progress state, the RGB LED code and any recovered candidate. It sits between the top-level buttons, the SD_SIM BRAM port and the encrypter.

## Interface
- DICT_START, 2: BRAM address of the first dictionary word.
- DICT_SIZE, 3: number of dictionary words (0 allowed).
- BRUTE_ATTEMPTS, 10: number of brute candidates (0 allowed).
- TIMEOUT_CYCLES, 64: encrypter watchdog limit (used only with the macro).
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high; returns the block to WAIT.
- start  in  1  debounced level; a rising edge launches a job.
- mem_en  out  1  BRAM read enable.
- mem_addr  out  8  BRAM address.
- mem_dout  in  128  BRAM read data; valid 1 cycle after the address.
- enc_data  out  128  candidate plaintext.
- enc_key  out  128  salt key.
- enc_decrypt  out  1  tied 0 (encrypt mode).
- enc_start  out  1  one-cycle request pulse.
- enc_done  in  1  one-cycle completion pulse.
- enc_result  in  128  valid while enc_done=1.
- state  out  3  0 WAIT, 1 LOAD, 2 DICT, 3 BRUTE, 4 SUCCESS, 5 FAIL.
- led  out  3  RGB code.
- found  out  1  high in SUCCESS.
- found_key  out  128  matching candidate.
- attempts  out  32  number of comparisons performed in the current job.

## Operation
- Reset values: state=0, led=3'b000, all other outputs 0.
- Register every output.
- Start handling:
  - Detect the start rising edge internally from the registered start.
  - Ignore start edges in every state except WAIT.
- LED codes:
  - WAIT: 3'b011.
  - LOAD, DICT, BRUTE: 3'b100.
  - SUCCESS: 3'b010.
  - FAIL: 3'b001.
- LOAD state:
  - Read address 0 into the hash register, then address 1 into enc_key.
  - Each read takes 2 cycles: address cycle, then capture cycle.
- Candidate loop (substates RD, CAP, REQ, WT), shared by DICT and BRUTE:
  - RD (DICT only): mem_addr = DICT_START + idx, mem_en=1.
  - CAP (DICT only): enc_data <= mem_dout.
  - In BRUTE, skip RD and CAP; enc_data <= zero-extended idx.
  - REQ: enc_start=1 for exactly one cycle.
  - WT: hold until enc_done=1. On that cycle:
    - attempts increments.
    - If enc_result == hash: found_key <= enc_data, go to SUCCESS.
    - Otherwise idx increments.
- Transitions:
  - DICT to BRUTE when idx reaches DICT_SIZE. idx clears on entry to BRUTE.
  - BRUTE to FAIL when idx reaches BRUTE_ATTEMPTS.
  - LOAD with DICT_SIZE=0 goes directly to BRUTE.
  - Entering BRUTE with BRUTE_ATTEMPTS=0 goes directly to FAIL.
- enc_done outside WT is ignored.
- SUCCESS and FAIL are terminal; only reset leaves them.
- Reset mid-job: abort immediately; no further enc_start pulses are issued.
- A late enc_done arriving after reset is ignored.

## Timing
- From the start edge to the first REQ: 1 cycle (edge detect) + 4 cycles (LOAD) + 2 cycles (RD, CAP).
- Per dictionary candidate: 3 cycles + encrypter latency L (L ≥ 1).
- Per brute candidate: 1 cycle + L.
- state and led update on the clock edge after the WT compare.
- found rises together with state=4.

## Configuration
- CRACK_TIMEOUT_EN defined:
  - A watchdog counts WT cycles.
  - If it reaches TIMEOUT_CYCLES without enc_done, go to FAIL.
  - attempts is not incremented for the timed-out candidate.
- CRACK_TIMEOUT_EN undefined:
  - WT waits indefinitely.
  - TIMEOUT_CYCLES is unused.

## Structure
- Shared package crack_pkg holds:
  - the state encoding (0–5);
  - the LED constants;
  - HASH_ADDR=0 and KEY_ADDR=1;
  - the substate enum.
- One sub-module, crack_watchdog: a cycle counter with clear/enable and a timeout flag. It is instantiated only under CRACK_TIMEOUT_EN.

## Test plan
Bench setup: encrypter model with enc_result = data ^ key and L=3; key = 128'h0F0F…0F. Set mem[0] to the hash of the chosen secret.
- Secret is dictionary word 2 (mem[3]) → SUCCESS, attempts=2, found_key=mem[3], led=3'b010.
- Secret is 7 with no dictionary match → DICT exhausted after 3 compares, then BRUTE; SUCCESS with attempts=11 and found_key=128'd7.
- No match anywhere → FAIL after attempts=13, led=3'b001.
- With DICT_SIZE=0 and secret 0 → BRUTE entered straight from LOAD; SUCCESS with attempts=1.
- Reset asserted during the WT of candidate 2, then a late enc_done → state=0, no enc_start pulse; restart gives correct results.
- CRACK_TIMEOUT_EN with enc_done never asserted → FAIL TIMEOUT_CYCLES cycles after REQ, attempts=0.
- Start edges in DICT and SUCCESS → no effect.
